// File: rtl/param_stack_pkg.sv
// rtl/param_stack_pkg.sv - shared defaults and operation encoding for the parametrised LIFO stack
package param_stack_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Encoding is {push, pop}, so the request pair maps onto an op without a lookup.
  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PUSH    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

endpackage

// File: rtl/param_stack_if.sv
// rtl/param_stack_if.sv - request/status bundle between a stack user and param_stack
interface param_stack_if
  import param_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
);

  logic             en;
  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output en, clear, push, pop, data_in,
    input  top, pop_data, pop_valid, count, full, empty, overflow, underflow
  );

  modport slave (
    input  en, clear, push, pop, data_in,
    output top, pop_data, pop_valid, count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/param_stack_mem.sv
// rtl/param_stack_mem.sv - DEPTH x WIDTH register array, one write port, async read of the top slot
module stack_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// rtl/param_stack.sv - LIFO stack with push/pop/replace, top-of-stack view, count and sticky error flags
module param_stack
  import param_stack_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  param_stack_if.slave  bus
);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic [1:0]       op;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] mem_top;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign op       = {bus.push, bus.pop};
  assign top_addr = AW'(count - CNT_W'(1));

  // Every memory write (push, zero-on-pop, replace) goes through the single port.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!bus.clear && bus.en) begin
      case (op)
        OP_PUSH: if (!full) begin
          we    = 1'b1;
          waddr = AW'(count);
          wdata = bus.data_in;
        end
        OP_POP: if (!empty) begin
          we    = 1'b1;
          waddr = top_addr;
        end
        OP_REPLACE: begin
          we    = 1'b1;
          waddr = empty ? '0 : top_addr;
          wdata = bus.data_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clear) begin
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!bus.en) begin
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (full) overflow <= 1'b1;
          else      count    <= count + CNT_W'(1);
        end
        OP_POP: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            pop_data  <= mem_top;
            pop_valid <= 1'b1;
            count     <= count - CNT_W'(1);
          end
        end
        OP_REPLACE: begin
          // On an empty stack the push half still lands; only the pop half is refused.
          if (empty) begin
            underflow <= 1'b1;
            count     <= count + CNT_W'(1);
          end else begin
            pop_data  <= mem_top;
            pop_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_addr),
    .rdata (mem_top)
  );

  assign bus.top       = empty ? '0 : mem_top;
  assign bus.pop_data  = pop_data;
  assign bus.pop_valid = pop_valid;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_param_stack.sv
// tb/tb_param_stack.sv - vector-table bench for param_stack with a pop_data scoreboard
module tb_param_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;

  param_stack_if #(.WIDTH(4), .DEPTH(4)) bus ();

  param_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, clr, push, pop;
    logic [3:0] din;
    logic [3:0] top;
    logic [2:0] cnt;
    logic       ovf, unf, pv;
    logic [3:0] pd;
  } vec_t;

  vec_t       vecs [28];
  logic [3:0] sb_q [$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic clr, input logic push, input logic pop,
                              input logic [3:0] din, input logic [3:0] top, input logic [2:0] cnt,
                              input logic ovf, input logic unf, input logic pv, input logic [3:0] pd);
    vec_t v;
    v.en = en; v.clr = clr; v.push = push; v.pop = pop; v.din = din;
    v.top = top; v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.pv = pv; v.pd = pd;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.en = 1'b1; bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
  endtask

  task automatic check_state(input string tag, input logic [3:0] top, input logic [2:0] cnt,
                             input logic ovf, input logic unf, input logic pv);
    chk({tag, " top"},       int'(bus.top),       int'(top));
    chk({tag, " count"},     int'(bus.count),     int'(cnt));
    chk({tag, " full"},      int'(bus.full),      int'(cnt == 3'd4));
    chk({tag, " empty"},     int'(bus.empty),     int'(cnt == 3'd0));
    chk({tag, " overflow"},  int'(bus.overflow),  int'(ovf));
    chk({tag, " underflow"}, int'(bus.underflow), int'(unf));
    chk({tag, " pop_valid"}, int'(bus.pop_valid), int'(pv));
  endtask

  initial begin
    idle_inputs();

    // Reset state before any clock edge.
    #1;
    check_state("reset", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset pop_data", int'(bus.pop_data), 0);

    // Load two entries, then assert reset asynchronously while a third push is pending.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); bus.push = 1'b1; bus.data_in = 4'd1;
    @(negedge clk); bus.data_in = 4'd2;
    @(negedge clk); bus.data_in = 4'd3;
    #2 rst = 1'b0;
    #1 check_state("async rst", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_state("rst mid-push", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    check_state("post rst", 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    //            en clr push pop din   top   cnt ovf unf pv pd
    vecs[0]  = mk(1, 0, 1, 0, 4'h1, 4'h1, 3'd1, 0, 0, 0, 4'h0);
    vecs[1]  = mk(1, 0, 1, 0, 4'h2, 4'h2, 3'd2, 0, 0, 0, 4'h0);
    vecs[2]  = mk(1, 0, 1, 0, 4'h3, 4'h3, 3'd3, 0, 0, 0, 4'h0);
    vecs[3]  = mk(1, 0, 1, 0, 4'h4, 4'h4, 3'd4, 0, 0, 0, 4'h0);
    vecs[4]  = mk(1, 0, 1, 0, 4'h9, 4'h4, 3'd4, 1, 0, 0, 4'h0);
    vecs[5]  = mk(1, 0, 0, 1, 4'h0, 4'h3, 3'd3, 1, 0, 1, 4'h4);
    vecs[6]  = mk(1, 0, 0, 1, 4'h0, 4'h2, 3'd2, 1, 0, 1, 4'h3);
    vecs[7]  = mk(1, 0, 0, 1, 4'h0, 4'h1, 3'd1, 1, 0, 1, 4'h2);
    vecs[8]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 3'd0, 1, 0, 1, 4'h1);
    vecs[9]  = mk(1, 0, 0, 1, 4'h0, 4'h0, 3'd0, 1, 1, 0, 4'h0);
    vecs[10] = mk(1, 1, 1, 0, 4'h5, 4'h0, 3'd0, 0, 0, 0, 4'h0);
    vecs[11] = mk(1, 0, 1, 0, 4'hA, 4'hA, 3'd1, 0, 0, 0, 4'h0);
    vecs[12] = mk(1, 0, 1, 0, 4'hB, 4'hB, 3'd2, 0, 0, 0, 4'h0);
    vecs[13] = mk(1, 0, 1, 1, 4'hC, 4'hC, 3'd2, 0, 0, 1, 4'hB);
    vecs[14] = mk(0, 0, 1, 1, 4'h3, 4'hC, 3'd2, 0, 0, 0, 4'h0);
    vecs[15] = mk(0, 0, 0, 1, 4'h0, 4'hC, 3'd2, 0, 0, 0, 4'h0);
    vecs[16] = mk(1, 0, 1, 0, 4'h3, 4'h3, 3'd3, 0, 0, 0, 4'h0);
    vecs[17] = mk(1, 0, 1, 0, 4'h4, 4'h4, 3'd4, 0, 0, 0, 4'h0);
    vecs[18] = mk(1, 0, 1, 1, 4'h7, 4'h7, 3'd4, 0, 0, 1, 4'h4);
    vecs[19] = mk(1, 0, 0, 0, 4'h0, 4'h7, 3'd4, 0, 0, 0, 4'h0);
    vecs[20] = mk(1, 0, 0, 1, 4'h0, 4'h3, 3'd3, 0, 0, 1, 4'h7);
    vecs[21] = mk(1, 0, 0, 1, 4'h0, 4'hC, 3'd2, 0, 0, 1, 4'h3);
    vecs[22] = mk(1, 0, 0, 1, 4'h0, 4'hA, 3'd1, 0, 0, 1, 4'hC);
    vecs[23] = mk(1, 0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0, 1, 4'hA);
    vecs[24] = mk(1, 0, 1, 1, 4'h6, 4'h6, 3'd1, 0, 1, 0, 4'h0);
    vecs[25] = mk(1, 0, 0, 1, 4'h0, 4'h0, 3'd0, 0, 1, 1, 4'h6);
    vecs[26] = mk(1, 0, 1, 0, 4'h2, 4'h2, 3'd1, 0, 1, 0, 4'h0);
    vecs[27] = mk(1, 1, 0, 1, 4'h0, 4'h0, 3'd0, 0, 0, 0, 4'h0);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      bus.en = vecs[i].en; bus.clear = vecs[i].clr;
      bus.push = vecs[i].push; bus.pop = vecs[i].pop; bus.data_in = vecs[i].din;
      if (vecs[i].pv) sb_q.push_back(vecs[i].pd);
      @(posedge clk); #1;
      check_state($sformatf("vec%0d", i), vecs[i].top, vecs[i].cnt,
                  vecs[i].ovf, vecs[i].unf, vecs[i].pv);
      if (bus.pop_valid) begin
        if (sb_q.size() == 0) chk($sformatf("vec%0d unexpected pop", i), 1, 0);
        else chk($sformatf("vec%0d pop_data", i), int'(bus.pop_data), int'(sb_q.pop_front()));
      end
    end

    @(negedge clk); idle_inputs();
    chk("scoreboard drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
